// File: rtl/wb_pkg.sv
// wb_pkg: shared definitions for the write-back buffer.
//   - default result / register-address widths
//   - REG_ZERO: the hardwired-zero register address (writes to it are dropped)
//   - entry layout {rd[ADDR_W-1:0], data[DATA_W-1:0]}: data in the low bits,
//     destination above it. Offsets below are for the default widths; the
//     parameterized helpers give the same layout for any width.
package wb_pkg;
  localparam int DATA_W_DEF = 32;
  localparam int ADDR_W_DEF = 5;

  localparam logic [4:0] REG_ZERO = 5'd0;

  localparam int ENT_DATA_LSB = 0;
  localparam int ENT_RD_LSB   = DATA_W_DEF;
  localparam int ENT_W        = ADDR_W_DEF + DATA_W_DEF;

  function automatic int ent_w(input int aw, input int dw);
    return aw + dw;
  endfunction

  function automatic int ent_rd_lsb(input int dw);
    return dw;
  endfunction
endpackage

// File: rtl/wb_match.sv
// wb_match: forwarding lookup across the queued entries.
// Ports:
//   ent_i   - entry array, {rd, data} per slot
//   vld_i   - per-slot occupancy mask
//   head_i  - slot index of the oldest entry
//   addr_i  - lookup register address (x0 never hits)
//   hit_o   - some valid entry targets addr_i
//   data_o  - data of the youngest matching entry, 0 when no hit
module wb_match import wb_pkg::*; #(
  parameter int DEPTH  = 4,
  parameter int DATA_W = DATA_W_DEF,
  parameter int ADDR_W = ADDR_W_DEF,
  localparam int PW    = $clog2(DEPTH),
  localparam int EW    = ent_w(ADDR_W, DATA_W),
  localparam int RDL   = ent_rd_lsb(DATA_W)
) (
  input  logic [DEPTH-1:0][EW-1:0] ent_i,
  input  logic [DEPTH-1:0]         vld_i,
  input  logic [PW-1:0]            head_i,
  input  logic [ADDR_W-1:0]        addr_i,
  output logic                     hit_o,
  output logic [DATA_W-1:0]        data_o
);
  logic [PW-1:0] idx;

  // Walk oldest -> youngest; a later match overwrites an earlier one, so the
  // youngest entry wins.
  always_comb begin
    hit_o  = 1'b0;
    data_o = '0;
    idx    = head_i;
    for (int i = 0; i < DEPTH; i++) begin
      idx = head_i + PW'(i);
      if (vld_i[idx] && addr_i != ADDR_W'(REG_ZERO) &&
          ent_i[idx][RDL +: ADDR_W] == addr_i) begin
        hit_o  = 1'b1;
        data_o = ent_i[idx][DATA_W-1:0];
      end
    end
  end
endmodule

// File: rtl/wb_buffer.sv
// wb_buffer: write-side feeder for the register file.
// Accepts ALU and load results (load has priority), queues them in an in-order
// FIFO and drains one entry per cycle onto the register-file write port.
// Ports:
//   clk, rst_n                 - clock, async active-low reset
//   alu_* / ld_*               - result handshakes (valid/ready, rd, data)
//   wb_stall                   - holds the drain this cycle
//   RegWrite/rd_addr/write_data- register-file write port (combinational from head)
//   rs1/rs2_addr, _hit, _fwd   - forwarding lookups into the queue
//   count                      - occupancy
// Config: define WB_BYPASS_EN to build the forwarding lookups; otherwise the
// hit/fwd outputs are tied to 0.
module wb_buffer import wb_pkg::*; #(
  parameter int DEPTH  = 4,
  parameter int DATA_W = DATA_W_DEF,
  parameter int ADDR_W = ADDR_W_DEF,
  localparam int PW    = $clog2(DEPTH),
  localparam int CW    = $clog2(DEPTH) + 1,
  localparam int EW    = ent_w(ADDR_W, DATA_W),
  localparam int RDL   = ent_rd_lsb(DATA_W)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              alu_valid,
  output logic              alu_ready,
  input  logic [ADDR_W-1:0] alu_rd,
  input  logic [DATA_W-1:0] alu_data,
  input  logic              ld_valid,
  output logic              ld_ready,
  input  logic [ADDR_W-1:0] ld_rd,
  input  logic [DATA_W-1:0] ld_data,
  input  logic              wb_stall,
  output logic              RegWrite,
  output logic [ADDR_W-1:0] rd_addr,
  output logic [DATA_W-1:0] write_data,
  input  logic [ADDR_W-1:0] rs1_addr,
  input  logic [ADDR_W-1:0] rs2_addr,
  output logic              rs1_hit,
  output logic              rs2_hit,
  output logic [DATA_W-1:0] rs1_fwd,
  output logic [DATA_W-1:0] rs2_fwd,
  output logic [CW-1:0]     count
);
  logic [DEPTH-1:0][EW-1:0] mem_q;
  logic [PW-1:0]            wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]            count_q, count_d;
  logic                     space, push, store, pop;
  logic [ADDR_W-1:0]        push_rd;
  logic [DATA_W-1:0]        push_data;
  logic [EW-1:0]            head;

  // Readiness looks only at the registered count: a same-cycle pop does not
  // free a slot for a push.
  assign space     = count_q < CW'(DEPTH);
  assign ld_ready  = space;
  assign alu_ready = space && !ld_valid;

  assign push      = (ld_valid && ld_ready) || (alu_valid && alu_ready);
  assign push_rd   = ld_valid ? ld_rd   : alu_rd;
  assign push_data = ld_valid ? ld_data : alu_data;
  // x0 results are handshaken but never occupy a slot.
  assign store     = push && (push_rd != ADDR_W'(REG_ZERO));

  assign head       = mem_q[rd_ptr_q];
  assign RegWrite   = (count_q != '0) && !wb_stall;
  assign pop        = RegWrite;
  assign rd_addr    = (count_q != '0) ? head[RDL +: ADDR_W] : '0;
  assign write_data = (count_q != '0) ? head[DATA_W-1:0]    : '0;
  assign count      = count_q;

  assign wr_ptr_d = store ? wr_ptr_q + PW'(1) : wr_ptr_q;
  assign rd_ptr_d = pop   ? rd_ptr_q + PW'(1) : rd_ptr_q;
  assign count_d  = count_q + CW'(store) - CW'(pop);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage needs no reset: count gates every read of it.
  always_ff @(posedge clk) begin
    if (store) mem_q[wr_ptr_q] <= {push_rd, push_data};
  end

`ifdef WB_BYPASS_EN
  logic [DEPTH-1:0]         vld;
  logic [1:0][ADDR_W-1:0]   lu_addr;
  logic [1:0]               lu_hit;
  logic [1:0][DATA_W-1:0]   lu_data;

  // Slot j is occupied when its distance from the head is below count.
  always_comb begin
    vld = '0;
    for (int j = 0; j < DEPTH; j++)
      vld[j] = CW'(PW'(j) - rd_ptr_q) < count_q;
  end

  assign lu_addr = {rs2_addr, rs1_addr};

  for (genvar g = 0; g < 2; g++) begin : g_lu
    wb_match #(.DEPTH(DEPTH), .DATA_W(DATA_W), .ADDR_W(ADDR_W)) u_match (
      .ent_i  (mem_q),
      .vld_i  (vld),
      .head_i (rd_ptr_q),
      .addr_i (lu_addr[g]),
      .hit_o  (lu_hit[g]),
      .data_o (lu_data[g])
    );
  end

  assign rs1_hit = lu_hit[0];
  assign rs2_hit = lu_hit[1];
  assign rs1_fwd = lu_data[0];
  assign rs2_fwd = lu_data[1];
`else
  logic unused_lookup;
  assign unused_lookup = ^{rs1_addr, rs2_addr};
  assign rs1_hit = 1'b0;
  assign rs2_hit = 1'b0;
  assign rs1_fwd = '0;
  assign rs2_fwd = '0;
`endif
endmodule

// File: tb/tb_wb_buffer.sv
module tb_wb_buffer;
  logic        clk = 1'b0, rst_n = 1'b0;
  logic        alu_valid = 0, ld_valid = 0, wb_stall = 0;
  logic        alu_ready, ld_ready, RegWrite, rs1_hit, rs2_hit;
  logic [4:0]  alu_rd = 0, ld_rd = 0, rd_addr, rs1_addr = 0, rs2_addr = 0;
  logic [31:0] alu_data = 0, ld_data = 0, write_data, rs1_fwd, rs2_fwd;
  logic [2:0]  count;
  int          n_tests = 0, n_fail = 0;
  logic        byp;

  always #5 clk = ~clk;

  wb_buffer dut (
    .clk(clk), .rst_n(rst_n),
    .alu_valid(alu_valid), .alu_ready(alu_ready), .alu_rd(alu_rd), .alu_data(alu_data),
    .ld_valid(ld_valid), .ld_ready(ld_ready), .ld_rd(ld_rd), .ld_data(ld_data),
    .wb_stall(wb_stall), .RegWrite(RegWrite), .rd_addr(rd_addr), .write_data(write_data),
    .rs1_addr(rs1_addr), .rs2_addr(rs2_addr), .rs1_hit(rs1_hit), .rs2_hit(rs2_hit),
    .rs1_fwd(rs1_fwd), .rs2_fwd(rs2_fwd), .count(count)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Advance past the next rising edge; inputs change and outputs are sampled
  // 1 time unit after it.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
`ifdef WB_BYPASS_EN
    byp = 1'b1;
`else
    byp = 1'b0;
`endif
    // Reset state
    #2;
    chk("rst_count", count, 0);
    chk("rst_regwrite", RegWrite, 0);
    chk("rst_rd_addr", rd_addr, 0);
    chk("rst_wdata", write_data, 0);
    chk("rst_hit", {rs1_hit, rs2_hit}, 0);
    chk("rst_fwd", rs1_fwd, 0);
    tick(); tick();
    rst_n = 1'b1;
    tick();

    // Single ALU push, written the next cycle
    alu_valid = 1; alu_rd = 5; alu_data = 32'hDEADBEEF;
    #1;
    chk("p1_alu_ready", alu_ready, 1);
    chk("p1_regwrite_pre", RegWrite, 0);
    tick();
    alu_valid = 0;
    #1;
    chk("p1_regwrite", RegWrite, 1);
    chk("p1_rd_addr", rd_addr, 5);
    chk("p1_wdata", write_data, 32'hDEADBEEF);
    chk("p1_count", count, 1);
    tick();
    chk("p1_count_after", count, 0);
    chk("p1_regwrite_after", RegWrite, 0);

    // Load beats ALU
    ld_valid = 1; ld_rd = 3; ld_data = 32'h11;
    alu_valid = 1; alu_rd = 4; alu_data = 32'h22;
    #1;
    chk("pri_ld_ready", ld_ready, 1);
    chk("pri_alu_ready", alu_ready, 0);
    tick();
    ld_valid = 0;
    #1;
    chk("pri_alu_ready2", alu_ready, 1);
    chk("pri_rd_ld", rd_addr, 3);
    chk("pri_wd_ld", write_data, 32'h11);
    tick();
    alu_valid = 0;
    #1;
    chk("pri_rd_alu", rd_addr, 4);
    chk("pri_wd_alu", write_data, 32'h22);
    chk("pri_count", count, 1);
    tick();
    chk("pri_count_end", count, 0);

    // Fill under stall, then drain in order
    wb_stall = 1;
    for (int i = 1; i <= 4; i++) begin
      alu_valid = 1; alu_rd = 5'(i); alu_data = 32'h100 + i;
      tick();
    end
    alu_valid = 0; ld_valid = 1; ld_rd = 9; ld_data = 32'h99;
    rs1_addr = 3; rs2_addr = 8;
    #1;
    chk("full_count", count, 4);
    chk("full_alu_ready", alu_ready, 0);
    chk("full_ld_ready", ld_ready, 0);
    chk("full_regwrite", RegWrite, 0);
    chk("full_rs1_hit", rs1_hit, byp);
    chk("full_rs1_fwd", rs1_fwd, byp ? 32'h103 : 32'h0);
    chk("full_rs2_hit", rs2_hit, 0);
    tick();
    chk("full_hold", count, 4);
    ld_valid = 0; wb_stall = 0;
    for (int i = 1; i <= 4; i++) begin
      #1;
      chk("drain_we", RegWrite, 1);
      chk("drain_rd", rd_addr, 5'(i));
      chk("drain_wd", write_data, 32'h100 + i);
      tick();
    end
    chk("drain_count", count, 0);

    // x0 push: accepted, not stored
    alu_valid = 1; alu_rd = 0; alu_data = 32'hFFFFFFFF; rs1_addr = 0;
    #1;
    chk("x0_ready", alu_ready, 1);
    chk("x0_hit", rs1_hit, 0);
    tick();
    alu_valid = 0;
    #1;
    chk("x0_count", count, 0);
    chk("x0_regwrite", RegWrite, 0);
    tick();
    chk("x0_regwrite2", RegWrite, 0);

    // Youngest-match forwarding with duplicate rd
    wb_stall = 1; rs1_addr = 7; rs2_addr = 9;
    alu_valid = 1; alu_rd = 7; alu_data = 32'hA;
    tick();
    alu_data = 32'hB;
    tick();
    alu_valid = 0;
    #1;
    chk("fwd_count", count, 2);
    chk("fwd_hit", rs1_hit, byp);
    chk("fwd_data", rs1_fwd, byp ? 32'hB : 32'h0);
    chk("fwd_miss", rs2_hit, 0);
    chk("fwd_miss_data", rs2_fwd, 0);
    wb_stall = 0;
    #1;
    chk("dup1_rd", rd_addr, 7);
    chk("dup1_wd", write_data, 32'hA);
    chk("dup1_hit", rs1_hit, byp);
    tick();
    chk("dup2_wd", write_data, 32'hB);
    chk("dup2_fwd", rs1_fwd, byp ? 32'hB : 32'h0);
    tick();
    chk("dup_count", count, 0);

    // Asynchronous reset mid-cycle with 3 queued
    wb_stall = 1;
    for (int i = 0; i < 3; i++) begin
      alu_valid = 1; alu_rd = 5'(10 + i); alu_data = 32'h200 + i;
      tick();
    end
    alu_valid = 0; wb_stall = 0;
    #1;
    chk("pre_rst_count", count, 3);
    rst_n = 0;
    #1;
    chk("arst_count", count, 0);
    chk("arst_regwrite", RegWrite, 0);
    chk("arst_wdata", write_data, 0);
    tick();
    rst_n = 1;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("post_rst_no_write", RegWrite, 0);
    end
    chk("post_rst_count", count, 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
